// File: rtl/counter_pkg.sv
`default_nettype none
// counter_pkg: mode/state encodings and BCD sizing shared by bcd_mode_counter and bcd_digit.
// Revision 1.0
package counter_pkg;
  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    MODE_PAUSE = 2'd0,
    MODE_UP    = 2'd1,
    MODE_DOWN  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_t;
endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// bcd_digit: one decimal decade (0..9) with ripple carry (up) and borrow (down) out.
// Revision 1.0
module bcd_digit
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             cin,
  input  logic             bin,
  output logic [BCD_W-1:0] digit,
  output logic             cout,
  output logic             bout
);
  localparam logic [BCD_W-1:0] DIG_MAX = BCD_W'(9);
  localparam logic [BCD_W-1:0] DIG_ONE = BCD_W'(1);

  logic [BCD_W-1:0] digit_r;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit_r <= '0;
    end else if (en && up && cin) begin
      digit_r <= (digit_r == DIG_MAX) ? '0 : digit_r + DIG_ONE;
    end else if (en && !up && bin) begin
      digit_r <= (digit_r == '0) ? DIG_MAX : digit_r - DIG_ONE;
    end
  end

  // Carry/borrow are purely combinational so the whole chain settles in one cycle.
  assign cout  = up & cin & (digit_r == DIG_MAX);
  assign bout  = ~up & bin & (digit_r == '0);
  assign digit = digit_r;
endmodule
`default_nettype wire

// File: rtl/bcd_mode_counter.sv
`default_nettype none
// bcd_mode_counter: key-selected pause/up/down/clear 4-digit BCD counter on a prescaled tick.
// Optional COUNTER_SATURATE_EN: stop at 9999/0000 instead of wrapping. Revision 1.0
module bcd_mode_counter
  import counter_pkg::*;
#(
  parameter logic [25:0] CNT_TICK_MAX = 26'd49_999_999,
  parameter int          DIGITS       = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [1:0]                key_select,
  input  logic                      key_en,
  output logic [DIGITS*BCD_W-1:0]   bcd_data,
  output logic [1:0]                mode_state,
  output logic                      tick,
  output logic                      wrap
);
  mode_t         state_q;
  mode_t         state_d;
  logic [25:0]   presc;
  logic          run;
  logic          terminal;
  logic          step;
  logic          at_limit;
  logic          digit_up;
  logic          digit_clr;
  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;

  always_comb begin
    state_d = state_q;
    if (key_en) begin
      state_d = mode_t'(key_select);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= MODE_PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  assign run       = (state_q == MODE_UP) || (state_q == MODE_DOWN);
  // A key press on the terminal cycle takes priority and swallows the step.
  assign terminal  = run && !key_en && (presc == CNT_TICK_MAX);
  assign digit_up  = (state_q == MODE_UP);
  assign digit_clr = (state_q == MODE_CLEAR);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || key_en || digit_clr || terminal) begin
      presc <= '0;
    end else if (run) begin
      presc <= presc + 26'd1;
    end
  end

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .en    (step),
      .up    (digit_up),
      .clr   (digit_clr),
      .cin   (carry[i]),
      .bin   (borrow[i]),
      .digit (bcd_data[i*BCD_W +: BCD_W]),
      .cout  (carry[i+1]),
      .bout  (borrow[i+1])
    );
  end

  // Carry out of the top decade only exists going up, borrow only going down.
  assign at_limit = carry[DIGITS] | borrow[DIGITS];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick <= 1'b0;
    end else begin
      tick <= terminal;
    end
  end

`ifdef COUNTER_SATURATE_EN
  assign step = terminal && !at_limit;
  assign wrap = 1'b0;
`else
  assign step = terminal;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= terminal && at_limit;
    end
  end
`endif

  assign mode_state = state_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_mode_counter.sv
`default_nettype none
// tb_bcd_mode_counter: randomized and directed checks against an integer-count reference model.
// Revision 1.0
module tb_bcd_mode_counter;
  localparam int MAX = 3;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [1:0]  key_select = 2'd0;
  logic        key_en = 1'b0;
  logic [15:0] bcd_data;
  logic [1:0]  mode_state;
  logic        tick;
  logic        wrap;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain decimal count, mode number, prescaler count.
  int cnt = 0;
  int mode = 0;
  int pre = 0;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;

  bcd_mode_counter #(.CNT_TICK_MAX(26'd3), .DIGITS(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_select (key_select),
    .key_en     (key_en),
    .bcd_data   (bcd_data),
    .mode_state (mode_state),
    .tick       (tick),
    .wrap       (wrap)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    r = '0;
    v = n;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model_step(input bit en, input int sel, input bit rst);
    if (rst) begin
      mode = 0; cnt = 0; pre = 0; m_tick = 0; m_wrap = 0;
      return;
    end
    m_tick = 0;
    m_wrap = 0;
    if (mode == 3) cnt = 0;
    if (en) begin
      pre  = 0;
      mode = sel;
    end else if (mode == 1 || mode == 2) begin
      if (pre == MAX) begin
        pre = 0;
        m_tick = 1;
        if (mode == 1) begin
          if (cnt == 9999) begin
            if (!SAT) begin cnt = 0; m_wrap = 1; end
          end else cnt = cnt + 1;
        end else begin
          if (cnt == 0) begin
            if (!SAT) begin cnt = 9999; m_wrap = 1; end
          end else cnt = cnt - 1;
        end
      end else begin
        pre = pre + 1;
      end
    end else if (mode == 3) begin
      pre = 0;
    end
  endfunction

  task automatic cycle(input bit en, input int sel, input bit rst);
    key_en     = en;
    key_select = 2'(sel);
    sys_rst    = rst;
    @(posedge sys_clk);
    model_step(en, sel, rst);
    @(negedge sys_clk);
    check_val("bcd", 32'(bcd_data), 32'(to_bcd(cnt)));
    check_val("mode", 32'(mode_state), 32'(mode));
    check_val("tick", 32'(tick), 32'(m_tick));
    check_val("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  // Press a key, then count clocks until the first tick appears.
  task automatic measure(input string tag, input int sel);
    int n;
    cycle(1'b1, sel, 1'b0);
    n = 0;
    do begin
      cycle(1'b0, 0, 1'b0);
      n++;
    end while (!tick && n < 12);
    check_val(tag, 32'(n), 32'd4);
  endtask

  initial begin
    int guard;
    // Reset, with a key press during reset that must be ignored.
    cycle(1'b1, 1, 1'b1);
    cycle(1'b1, 2, 1'b1);
    repeat (20) cycle(1'b0, 0, 1'b0);
    check_val("idle_bcd", 32'(bcd_data), 32'h0);

    // Count up to 0042, passing 0009->0010.
    measure("first_up_tick", 1);
    repeat (167) cycle(1'b0, 0, 1'b0);
    check_val("cnt42", 32'(bcd_data), 32'h0042);

    // Clear, hold, pause, resume.
    cycle(1'b1, 3, 1'b0);
    cycle(1'b0, 0, 1'b0);
    check_val("clear_bcd", 32'(bcd_data), 32'h0);
    repeat (20) cycle(1'b0, 0, 1'b0);
    check_val("clear_hold", 32'(bcd_data), 32'h0);
    cycle(1'b1, 0, 1'b0);
    repeat (5) cycle(1'b0, 0, 1'b0);
    measure("resume_up_tick", 1);

    // Collision: re-select UP on the terminal-count cycle.
    guard = 0;
    while (pre != MAX && guard < 10) begin
      cycle(1'b0, 0, 1'b0);
      guard++;
    end
    check_val("reach_terminal", 32'(pre), 32'(MAX));
    cycle(1'b1, 1, 1'b0);
    check_val("collision_tick", 32'(tick), 32'd0);
    guard = 0;
    do begin
      cycle(1'b0, 0, 1'b0);
      guard++;
    end while (!tick && guard < 12);
    check_val("collision_next", 32'(guard), 32'd4);

    // DOWN from 0000.
    cycle(1'b1, 3, 1'b0);
    cycle(1'b0, 0, 1'b0);
    measure("first_down_tick", 2);
    check_val("down_first", 32'(bcd_data), SAT ? 32'h0 : 32'h9999);
    check_val("down_wrap", 32'(wrap), SAT ? 32'd0 : 32'd1);
    repeat (4) cycle(1'b0, 0, 1'b0);
    check_val("down_second", 32'(bcd_data), SAT ? 32'h0 : 32'h9998);
    check_val("down_nowrap", 32'(wrap), 32'd0);

    // Randomized keys and occasional reset.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 149) == 0);
    end

    // Full UP run through 9999.
    cycle(1'b1, 3, 1'b0);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 1, 1'b0);
    repeat (4 * 9999) cycle(1'b0, 0, 1'b0);
    check_val("at_9999", 32'(bcd_data), 32'h9999);
    repeat (4) cycle(1'b0, 0, 1'b0);
    check_val("past_9999", 32'(bcd_data), SAT ? 32'h9999 : 32'h0);
    check_val("up_wrap", 32'(wrap), SAT ? 32'd0 : 32'd1);
    check_val("up_tick", 32'(tick), 32'd1);
    repeat (12) cycle(1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
